score_cal_fetch_ctrl: RTL and testbench

- Sequences the point-score datapath: for each of `num_pairs` descriptor pairs it reads 5 bytes from feature memory A and 5 from feature memory B.
- It packs the bytes into two 40-bit words and presents them to the score calculation unit over a valid/ready handshake.
- Sits between the two feature RAMs and the score/compare stage; issues all RAM reads and tracks pair progress.

---
 rtl/score_cal_fetch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_score_cal_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_cal_fetch_ctrl.sv
// Fetch sequencer for the point-score datapath: reads NUM_BYTES bytes per descriptor
// from feature RAMs A and B, packs them into words and hands each pair downstream.
module score_cal_fetch_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int NUM_BYTES = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_W-1:0]      num_pairs,
    input  logic [ADDR_W-1:0]      base_a,
    input  logic [ADDR_W-1:0]      base_b,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr_a,
    output logic [ADDR_W-1:0]      mem_addr_b,
    input  logic [7:0]             mem_data_a,
    input  logic [7:0]             mem_data_b,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [NUM_BYTES*8-1:0] word_a,
    output logic [NUM_BYTES*8-1:0] word_b,
    output logic [ADDR_W-1:0]      pair_idx,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             state_dbg
);

    localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NUM_BYTES - 1);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(NUM_BYTES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LAST    = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  byte_cnt;
    logic [CNT_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] num_pairs_q;
    logic [ADDR_W-1:0] base_a_q;
    logic [ADDR_W-1:0] base_b_q;
    logic [ADDR_W-1:0] pair_off;
    logic [ADDR_W-1:0] next_off;

    assign state_dbg = state_q;

    // Byte that the data currently on mem_data_* belongs to (previous read).
    assign wr_idx   = byte_cnt - CNT_W'(1);
    assign next_off = pair_off + ADDR_W'(byte_cnt) + ADDR_W'(1);

    // Handshake: word_valid rises with a complete pair and holds word_a/word_b/pair_idx
    // stable until the cycle word_ready is also high; that edge transfers the pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_cnt    <= '0;
            num_pairs_q <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            pair_off    <= '0;
            mem_rd_en   <= 1'b0;
            mem_addr_a  <= '0;
            mem_addr_b  <= '0;
            word_valid  <= 1'b0;
            word_a      <= '0;
            word_b      <= '0;
            pair_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (abort && state_q != IDLE) begin
            state_q    <= IDLE;
            byte_cnt   <= '0;
            mem_rd_en  <= 1'b0;
            word_valid <= 1'b0;
            pair_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (num_pairs != '0) begin
                            num_pairs_q <= num_pairs;
                            base_a_q    <= base_a;
                            base_b_q    <= base_b;
                            pair_idx    <= '0;
                            pair_off    <= '0;
                            byte_cnt    <= '0;
                            word_a      <= '0;
                            word_b      <= '0;
                            mem_rd_en   <= 1'b1;
                            mem_addr_a  <= base_a;
                            mem_addr_b  <= base_b;
                            state_q     <= FETCH;
                        end else begin
                            done    <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (byte_cnt != '0) begin
                        word_a[8*int'(wr_idx) +: 8] <= mem_data_a;
                        word_b[8*int'(wr_idx) +: 8] <= mem_data_b;
                    end
                    if (byte_cnt == LAST_BYTE) begin
                        mem_rd_en <= 1'b0;
                        byte_cnt  <= '0;
                        state_q   <= LAST;
                    end else begin
                        byte_cnt   <= byte_cnt + CNT_W'(1);
                        mem_addr_a <= base_a_q + next_off;
                        mem_addr_b <= base_b_q + next_off;
                    end
                end
                LAST: begin
                    word_a[8*(NUM_BYTES-1) +: 8] <= mem_data_a;
                    word_b[8*(NUM_BYTES-1) +: 8] <= mem_data_b;
                    word_valid <= 1'b1;
                    state_q    <= PRESENT;
                end
                PRESENT: begin
                    if (word_ready) begin
                        word_valid <= 1'b0;
                        if (pair_idx == num_pairs_q - ADDR_W'(1)) begin
                            done    <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            // Next pair starts fetching immediately, no idle cycle.
                            pair_idx   <= pair_idx + ADDR_W'(1);
                            pair_off   <= pair_off + STRIDE;
                            word_a     <= '0;
                            word_b     <= '0;
                            mem_rd_en  <= 1'b1;
                            mem_addr_a <= base_a_q + pair_off + STRIDE;
                            mem_addr_b <= base_b_q + pair_off + STRIDE;
                            state_q    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_cal_fetch_ctrl.sv
// Bench for score_cal_fetch_ctrl: RAM model, table of runs, scoreboards for reads and
// presented pairs, plus hand-written abort / reset sequences.
module tb_score_cal_fetch_ctrl;

    localparam int ADDR_W = 8;
    localparam int NB     = 5;
    localparam int WW     = NB * 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] num_pairs;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr_a;
    logic [ADDR_W-1:0] mem_addr_b;
    logic [7:0]        mem_data_a;
    logic [7:0]        mem_data_b;
    logic              word_valid;
    logic              word_ready;
    logic [WW-1:0]     word_a;
    logic [WW-1:0]     word_b;
    logic [ADDR_W-1:0] pair_idx;
    logic              busy;
    logic              done;
    logic [2:0]        state_dbg;

    score_cal_fetch_ctrl #(.ADDR_W(ADDR_W), .NUM_BYTES(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_pairs(num_pairs), .base_a(base_a), .base_b(base_b),
        .mem_rd_en(mem_rd_en), .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
        .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
        .word_valid(word_valid), .word_ready(word_ready),
        .word_a(word_a), .word_b(word_b), .pair_idx(pair_idx),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Feature RAMs: synchronous read, data one cycle after the strobe.
    logic [7:0] ram_a [256];
    logic [7:0] ram_b [256];
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_data_a <= ram_a[mem_addr_a];
            mem_data_b <= ram_b[mem_addr_b];
        end
    end

    typedef struct {
        logic [7:0] ba;
        logic [7:0] bb;
        logic [7:0] n;
        int         stall_pair;
        int         stall_cycles;
        bit         inject;
        int         exp_done;
    } vec_t;

    vec_t        vecs[6];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [87:0] exp_q[$];
    logic [15:0] addr_q[$];
    int          stall_pair = -1;
    int          stall_left = 0;
    bit          inject = 1'b0;
    bit          injected = 1'b0;
    bit          stalled = 1'b0;
    logic [87:0] held;

    task automatic check(input string name, input logic [87:0] act, input logic [87:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive after the rising edge, observe on the falling edge.
    task automatic tick();
        logic [15:0] ea;
        logic [87:0] ew;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        abort = 1'b0;
        word_ready = !(word_valid && int'(pair_idx) == stall_pair && stall_left > 0);
        if (!word_ready) stall_left--;
        if (inject && word_valid && !injected) begin
            start     = 1'b1;
            num_pairs = 8'd5;
            injected  = 1'b1;
        end
        @(negedge clk);
        if (!rst) begin
            if (mem_rd_en) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: addr_a %0h addr_b %0h, expected no read",
                             mem_addr_a, mem_addr_b);
                end else begin
                    ea = addr_q.pop_front();
                    check("rd_addr", {72'd0, mem_addr_a, mem_addr_b}, {72'd0, ea});
                end
            end
            if (word_valid && stalled) check("stall_hold", {word_a, word_b, pair_idx}, held);
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: pair %0d word_a %0h, expected none",
                             pair_idx, word_a);
                end else begin
                    ew = exp_q.pop_front();
                    check("word", {word_a, word_b, pair_idx}, ew);
                end
            end
            stalled = word_valid && !word_ready;
            held    = {word_a, word_b, pair_idx};
        end
    endtask

    task automatic push_expect(input logic [7:0] ba, input logic [7:0] bb, input int n,
                               input int reads_limit);
        logic [7:0]    aa;
        logic [7:0]    ab;
        logic [WW-1:0] wa;
        logic [WW-1:0] wb;
        int            reads = 0;
        for (int p = 0; p < n; p++) begin
            for (int k = 0; k < NB; k++) begin
                aa = ba + 8'(p * NB + k);
                ab = bb + 8'(p * NB + k);
                if (reads < reads_limit) addr_q.push_back({aa, ab});
                reads++;
                wa[8*k +: 8] = ram_a[aa];
                wb[8*k +: 8] = ram_b[ab];
            end
            if (reads <= reads_limit) exp_q.push_back({wa, wb, 8'(p)});
        end
    endtask

    task automatic run_case(input vec_t v);
        int first_rd = -1;
        int first_valid = -1;
        int done_cyc = -1;
        int done_n = 0;
        int rd_n = 0;
        int t0;
        int rel;
        push_expect(v.ba, v.bb, int'(v.n), 1 << 30);
        stall_pair = v.stall_pair;
        stall_left = v.stall_cycles;
        inject     = v.inject;
        injected   = 1'b0;
        base_a     = v.ba;
        base_b     = v.bb;
        num_pairs  = v.n;
        start      = 1'b1;
        t0         = cyc;
        for (int i = 0; i < 300; i++) begin
            tick();
            rel = cyc - t0;
            if (mem_rd_en) begin
                rd_n++;
                if (first_rd < 0) first_rd = rel;
            end
            if (word_valid && first_valid < 0) first_valid = rel;
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = rel;
            end
            if (done_cyc >= 0 && rel >= done_cyc + 2) break;
        end
        check("done_cycle", 88'(done_cyc), 88'(v.exp_done));
        check("done_count", 88'(done_n), 88'd1);
        check("busy_after_done", {87'd0, busy}, 88'd0);
        if (v.n != 0) begin
            check("first_read_cycle", 88'(first_rd), 88'd1);
            check("first_valid_cycle", 88'(first_valid), 88'd7);
            check("read_count", 88'(rd_n), 88'(int'(v.n) * NB));
        end else begin
            check("no_reads", 88'(rd_n), 88'd0);
        end
        inject     = 1'b0;
        stall_pair = -1;
    endtask

    // Starts a run, lets three reads go out, then asserts abort or rst for one edge.
    task automatic interrupt_run(input logic [7:0] ba, input logic [7:0] bb, input bit use_rst);
        int done_n = 0;
        push_expect(ba, bb, 1, 3);
        base_a    = ba;
        base_b    = bb;
        num_pairs = 8'd2;
        start     = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
        tick();
        if (done) done_n++;
        check(use_rst ? "rst_ctrl_zero" : "abort_ctrl",
              {62'd0, mem_rd_en, mem_addr_a, mem_addr_b, word_valid, pair_idx, busy, done},
              use_rst ? 88'd0 : {62'd0, 1'b0, mem_addr_a, mem_addr_b, 1'b0, 8'd0, 1'b0, 1'b0});
        check(use_rst ? "rst_state" : "abort_state", {85'd0, state_dbg}, 88'd0);
        if (use_rst) begin
            check("rst_words_zero", {8'd0, word_a, word_b}, 88'd0);
            rst = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) done_n++;
        end
        check("no_done_after_stop", 88'(done_n), 88'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; word_ready = 1'b1;
        num_pairs = '0; base_a = '0; base_b = '0;
        for (int i = 0; i < 256; i++) begin
            ram_a[i] = 8'($urandom_range(0, 255));
            ram_b[i] = 8'($urandom_range(0, 255));
        end
        ram_a[8'h10] = 8'h11; ram_a[8'h11] = 8'h22; ram_a[8'h12] = 8'h33;
        ram_a[8'h13] = 8'h44; ram_a[8'h14] = 8'h55;

        //          ba     bb     n     stall_pair stall inject done
        vecs[0] = '{8'h10, 8'h40, 8'd1, -1,        0,    1'b0,  8};
        vecs[1] = '{8'h20, 8'h80, 8'd3,  1,        4,    1'b0,  26};
        vecs[2] = '{8'h00, 8'h00, 8'd0, -1,        0,    1'b0,  1};
        vecs[3] = '{8'hFE, 8'h7B, 8'd1, -1,        0,    1'b0,  8};
        vecs[4] = '{8'h30, 8'hF0, 8'd2,  0,        2,    1'b1,  17};
        vecs[5] = '{8'hA0, 8'hF8, 8'd4,  3,        1,    1'b0,  30};

        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        tick();
        check("reset_ctrl",
              {62'd0, mem_rd_en, mem_addr_a, mem_addr_b, word_valid, pair_idx, busy, done}, 88'd0);
        check("reset_words", {8'd0, word_a, word_b}, 88'd0);
        check("reset_state", {85'd0, state_dbg}, 88'd0);

        for (int i = 0; i < 6; i++) begin
            run_case(vecs[i]);
            if (i == 0) check("single_pair_word_a", {48'd0, word_a}, {48'd0, 40'h5544332211});
        end

        interrupt_run(8'h50, 8'h60, 1'b0);
        run_case(vecs[0]);
        interrupt_run(8'hC8, 8'h05, 1'b1);
        run_case(vecs[3]);

        check("addr_queue_empty", 88'(addr_q.size()), 88'd0);
        check("word_queue_empty", 88'(exp_q.size()), 88'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
